// File: rtl/seg_pkg.sv
// seg_pkg: shared types, constants and helpers for the 7-segment digit scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: scan_state_t FSM encoding, BCD_BLANK code, an_drive() anode polarity helper.
package seg_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        BLANK = ST_BLANK,
        SHOW  = ST_SHOW
    } scan_state_t;

    // Any code above 9 decodes to all segments off downstream; F is the canonical blank.
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Applies anode polarity to a one-hot (or all-zero) enable vector.
    // Fixed 32-bit width so it serves any digit count up to 32; callers truncate.
    function automatic logic [31:0] an_drive(input logic [31:0] onehot, input logic active_low);
        return active_low ? ~onehot : onehot;
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: per-slot cycle counter (0..SCAN_DIV-1) with blank-end / slot-end strobes.
// Latency: strobes are combinational decodes of the registered count.
// Backpressure: none; counts while run=1, holds while run=0, cleared whenever en=0.
// Ports: clk, rst_n (async active-low), en (clear when low), run (advance),
//        blank_end (last BLANK cycle), slot_end (last cycle of slot), slot_pre_end (one before slot_end).
module seg_slot_timer #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic run,
    output logic blank_end,
    output logic slot_end,
    output logic slot_pre_end
);

    localparam int             CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_PRE  = CW'(SCAN_DIV - 2);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign slot_end     = run && (cnt_q == CNT_LAST);
    // Lookahead lets the top register frame_done so it lands on the last SHOW cycle itself.
    assign slot_pre_end = run && (cnt_q == CNT_PRE);

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
            assign blank_end = run && (cnt_q == CNT_BLANK_LAST);
        end else begin : g_no_blank
            assign blank_end = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner: time-multiplexes NUM_DIGITS packed BCD digits onto one BCD bus + one-hot anodes.
// Latency: all outputs registered; pins follow en/load one clock after they are sampled.
// Backpressure: none; load is a strobe, digits are double-buffered so a frame never tears.
// Ports: clk, rst_n (async active-low), en (0 = dark), load + digits_in (digit 0 in [3:0]),
//        bcd_out (4'hF = blank), an_out (one-hot, polarity AN_ACTIVE_LOW), digit_idx, frame_done.
// Config: define SEG_LZB_EN to blank leading zeros (digit 0 is always shown). NUM_DIGITS <= 32.
module seg_digit_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_CYCLES  = 16,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int                    IW       = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};

    scan_state_t             state_q, state_n;
    logic                    blank_end, slot_end, slot_pre_end;
    logic [IW-1:0]           idx_n;
    logic [4*NUM_DIGITS-1:0] active_q, active_n, pending_q;
    logic                    pending_vld_q;
    logic                    frame_end_n;
    logic                    show_n;
    logic [3:0]              digit_sel, bcd_n;
    logic [NUM_DIGITS-1:0]   an_n;

    seg_slot_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .run          (state_q != IDLE),
        .blank_end    (blank_end),
        .slot_end     (slot_end),
        .slot_pre_end (slot_pre_end)
    );

    // digit_idx doubles as the index register; idx_n is its next value.
    always_comb begin
        state_n = state_q;
        idx_n   = digit_idx;
        if (!en) begin
            state_n = IDLE;
            idx_n   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_n = '0;
                    if (BLANK_CYCLES == 0) state_n = SHOW;
                    else                   state_n = BLANK;
                end
                BLANK: begin
                    if (blank_end) state_n = SHOW;
                end
                SHOW: begin
                    if (slot_end) begin
                        idx_n = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
                        if (BLANK_CYCLES == 0) state_n = SHOW;
                        else                   state_n = BLANK;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // frame_done (registered) marks the boundary cycle: the last SHOW clock of the last digit.
    always_comb begin
        active_n = active_q;
        if (frame_done) begin
            if (load)               active_n = digits_in;
            else if (pending_vld_q) active_n = pending_q;
        end else if (state_q == IDLE && load) begin
            active_n = digits_in;
        end
    end

    assign frame_end_n = en && (state_q == SHOW) && slot_pre_end && (digit_idx == IDX_LAST);
    assign show_n      = (state_n == SHOW);

    // Selection reads the post-update buffer so a frame's first SHOW already uses the new digits.
`ifdef SEG_LZB_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run   = zero_run && (active_n[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run && (k != 0);
        end
        digit_sel = lz_mask[idx_n] ? BCD_BLANK : active_n[{idx_n, 2'b00} +: 4];
    end
`else
    assign digit_sel = active_n[{idx_n, 2'b00} +: 4];
`endif

    assign bcd_n = show_n ? digit_sel : BCD_BLANK;
    assign an_n  = NUM_DIGITS'(an_drive(show_n ? (32'd1 << idx_n) : 32'd0, AN_ACTIVE_LOW != 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            digit_idx  <= '0;
            bcd_out    <= BCD_BLANK;
            an_out     <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            digit_idx  <= idx_n;
            bcd_out    <= bcd_n;
            an_out     <= an_n;
            frame_done <= frame_end_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q      <= {NUM_DIGITS{BCD_BLANK}};
            pending_q     <= '0;
            pending_vld_q <= 1'b0;
        end else begin
            active_q <= active_n;
            if (frame_done) begin
                pending_vld_q <= 1'b0;
            end else if (state_q == IDLE) begin
                // A direct load in IDLE supersedes anything still waiting in pending.
                if (load) pending_vld_q <= 1'b0;
            end else if (load) begin
                pending_q     <= digits_in;
                pending_vld_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_digit_scanner.sv
module tb_seg_digit_scanner;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  bcd_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx;
    logic        frame_done;

    seg_digit_scanner #(
        .NUM_DIGITS    (N),
        .SCAN_DIV      (SD),
        .BLANK_CYCLES  (BL),
        .AN_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digits_in  (digits_in),
        .bcd_out    (bcd_out),
        .an_out     (an_out),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] bcd;
        logic [3:0] an;
        logic [1:0] idx;
        logic       fd;
    } exp_t;

    exp_t q[$];
    exp_t last_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a scan timeline measured in cycles since scanning started,
    // plus the displayed / pending digit words.
    bit          m_run;
    int          m_t;
    logic [15:0] m_act;
    logic [15:0] m_pend;
    bit          m_pv;

    function automatic exp_t model_pins();
        exp_t       e;
        int         phase;
        int         slot;
        logic [3:0] d;
        e.bcd = 4'hF; e.an = 4'hF; e.idx = 2'd0; e.fd = 1'b0;
        if (m_run) begin
            phase = m_t % SD;
            slot  = (m_t / SD) % N;
            e.idx = 2'(slot);
            if (phase >= BL) begin
                d = 4'((m_act >> (4 * slot)) & 16'hF);
`ifdef SEG_LZB_EN
                if (slot > 0 && (m_act >> (4 * slot)) == 16'h0) d = 4'hF;
`endif
                e.bcd = d;
                e.an  = ~(4'b0001 << slot);
                e.fd  = (phase == SD - 1) && (slot == N - 1);
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_t = 0; m_act = 16'hFFFF; m_pv = 1'b0;
    endtask

    task automatic check(input string name, input exp_t got, input exp_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got bcd=%h an=%b idx=%0d fd=%b, expected bcd=%h an=%b idx=%0d fd=%b",
                     name, $time, got.bcd, got.an, got.idx, got.fd, exp.bcd, exp.an, exp.idx, exp.fd);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled there.
    task automatic step();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (last_e.fd) begin
                if (load)      m_act = digits_in;
                else if (m_pv) m_act = m_pend;
                m_pv = 1'b0;
            end else if (!m_run) begin
                if (load) begin m_act = digits_in; m_pv = 1'b0; end
            end else if (load) begin
                m_pend = digits_in; m_pv = 1'b1;
            end
            if (!en)         begin m_run = 1'b0; m_t = 0; end
            else if (!m_run) begin m_run = 1'b1; m_t = 0; end
            else             m_t++;
        end
        last_e = model_pins();
        q.push_back(last_e);
    endtask

    task automatic cyc(input logic e, input logic l, input logic [15:0] d);
        en = e; load = l; digits_in = d;
        @(posedge clk);
        step();
        #1;
    endtask

    // Reset pulse landing between edges: outputs must go dark without waiting for a clock.
    task automatic reset_pulse();
        @(posedge clk);
        model_reset();
        last_e = model_pins();
        q.push_back(last_e);
        #2 rst_n = 1'b0;
        #1 check("async_rst", {bcd_out, an_out, digit_idx, frame_done}, last_e);
        cyc(en, 1'b0, 16'h0);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < 4; k++)
            v[4*k +: 4] = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    task automatic wait_show();
        for (int i = 0; i < 40 && last_e.an == 4'hF; i++) cyc(1'b1, 1'b0, 16'h0);
    endtask

    // Monitor: compares every cycle's pins against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("scan", {bcd_out, an_out, digit_idx, frame_done}, e);
            end
        end
    end

    initial begin
        rst_n = 1'b1; en = 1'b0; load = 1'b0; digits_in = 16'h0;
        m_pend = 16'h0;
        model_reset();
        last_e = model_pins();
        #1 rst_n = 1'b0;
        #1 check("reset_hold", {bcd_out, an_out, digit_idx, frame_done}, last_e);
        repeat (3) cyc(1'b0, 1'b0, 16'h0);
        rst_n = 1'b1;

        // IDLE load then scan two full frames
        cyc(1'b0, 1'b1, 16'h1234);
        repeat (70) cyc(1'b1, 1'b0, 16'h0);

        // Load during digit-1 SHOW: held until the frame boundary
        for (int i = 0; i < 40 && !(last_e.idx == 2'd1 && last_e.an != 4'hF); i++)
            cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h5678);
        repeat (70) cyc(1'b1, 1'b0, 16'h0);

        // Load coincident with frame_done: shown in the very next frame
        for (int i = 0; i < 40 && !last_e.fd; i++) cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h9ABC);
        repeat (40) cyc(1'b1, 1'b0, 16'h0);

        // Two loads in one frame: the later one wins
        cyc(1'b1, 1'b1, 16'h1111);
        cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b1, 16'h2222);
        repeat (70) cyc(1'b1, 1'b0, 16'h0);

        // Enable drop mid-SHOW
        wait_show();
        cyc(1'b0, 1'b0, 16'h0);
        repeat (40) cyc(1'b1, 1'b0, 16'h0);

        // Async reset mid-SHOW, restart with blank digits
        wait_show();
        reset_pulse();
        repeat (40) cyc(1'b1, 1'b0, 16'h0);

        // Leading-zero patterns and pass-through of codes above 9
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 16'h0070);
        repeat (34) cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 16'h0000);
        repeat (34) cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b0, 1'b0, 16'h0);
        cyc(1'b0, 1'b1, 16'h0A0D);
        repeat (34) cyc(1'b1, 1'b0, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) reset_pulse();
            else cyc(r >= 20, (last_e.fd && r[0]) || ($urandom_range(0, 99) < 5), rand_digits());
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
